// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: resolves pipeline hazards into per-latch enable/flush strobes.
// It also runs the halt drain sequence (RUN -> DRAIN -> HALTED) and keeps a
// saturating count of stalled RUN cycles.
// Latch vectors below are ordered {ifid, idex, exmem, memwb}.
module pipeline_ctrl #(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 1
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_ihit,
  input  logic             i_dhit,
  input  logic             i_dmem_req,
  input  logic             i_exmem_redirect,
  input  logic             i_exmem_halt,
  input  logic             i_idex_memread,
  input  logic [4:0]       i_idex_rt,
  input  logic [4:0]       i_ifid_rs,
  input  logic [4:0]       i_ifid_rt,
  input  logic             i_ifid_uses_rt,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_idex_en,
  output logic             o_exmem_en,
  output logic             o_memwb_en,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic             o_exmem_flush,
  output logic             o_memwb_flush,
  output logic             o_halt,
  output logic [CNT_W-1:0] o_stall_count
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DRAIN_CYCLES - 1);

  state_t           r_state;
  logic [DW-1:0]    r_dcnt;
  logic             r_halt;
  logic [CNT_W-1:0] r_cnt;

  logic       w_mem_wait;
  logic       w_load_use;
  logic       w_enter_drain;
  logic       w_pc_en;
  logic [3:0] w_en;
  logic [3:0] w_fl;

  assign w_mem_wait = i_dmem_req & ~i_dhit;
  assign w_load_use = i_idex_memread & (i_idex_rt != 5'd0) &
                      ((i_idex_rt == i_ifid_rs) |
                       (i_ifid_uses_rt & (i_idex_rt == i_ifid_rt)));
  // mem_wait masks halt so the halt re-evaluates once the data access completes
  assign w_enter_drain = i_nrst & (r_state == S_RUN) & ~w_mem_wait & i_exmem_halt;

  // Strobe resolution: first matching hazard wins; everything quiet while in reset
  always_comb begin
    w_pc_en = 1'b0;
    w_en    = 4'b0000;
    w_fl    = 4'b0000;
    if (i_nrst) begin
      case (r_state)
        S_RUN: begin
          if (w_mem_wait) begin
            w_pc_en = 1'b0;
            w_en    = 4'b0000;
          end else if (i_exmem_halt) begin
            w_pc_en = 1'b0;
            w_en    = 4'b1111;
            w_fl    = 4'b1110;
          end else if (i_exmem_redirect) begin
            w_pc_en = 1'b1;
            w_en    = 4'b1111;
            w_fl    = 4'b1110;
          end else if (w_load_use) begin
            w_pc_en = 1'b0;
            w_en    = 4'b0111;
            w_fl    = 4'b0100;
          end else if (!i_ihit) begin
            w_pc_en = 1'b0;
            w_en    = 4'b1111;
            w_fl    = 4'b1000;
          end else begin
            w_pc_en = 1'b1;
            w_en    = 4'b1111;
          end
        end
        S_DRAIN: begin
          w_pc_en = 1'b0;
          w_en    = 4'b1111;
          w_fl    = 4'b1110;
        end
        default: begin
          w_pc_en = 1'b0;
          w_en    = 4'b0000;
        end
      endcase
    end
  end

  // Halt drain FSM; HALTED is left only through reset
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state <= S_RUN;
      r_dcnt  <= '0;
      r_halt  <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_enter_drain) begin
            r_state <= S_DRAIN;
            r_dcnt  <= '0;
          end
        end
        S_DRAIN: begin
          r_dcnt <= r_dcnt + DW'(1);
          if (r_dcnt == DLAST) begin
            r_state <= S_HALTED;
            r_halt  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_HALTED;
          r_halt  <= 1'b1;
        end
      endcase
    end
  end

  // Saturating count of RUN cycles where the PC did not advance
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_cnt <= '0;
    end else if ((r_state == S_RUN) && !w_pc_en && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_pc_en       = w_pc_en;
  assign o_ifid_en     = w_en[3];
  assign o_idex_en     = w_en[2];
  assign o_exmem_en    = w_en[1];
  assign o_memwb_en    = w_en[0];
  assign o_ifid_flush  = w_fl[3];
  assign o_idex_flush  = w_fl[2];
  assign o_exmem_flush = w_fl[1];
  assign o_memwb_flush = w_fl[0];
  assign o_halt        = r_halt;
  assign o_stall_count = r_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: the driver applies directed vectors just
// after each rising edge and queues hand-computed expectations; the monitor
// pops and checks on each falling edge.
module tb_pipeline_ctrl;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic       pc;
    logic [3:0] en;
    logic [3:0] fl;
    logic       h;
    logic [3:0] c;
  } exp_t;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic             ihit = 1'b0, dhit = 1'b0, dreq = 1'b0, redir = 1'b0, hlt = 1'b0;
  logic             memrd = 1'b0, uses = 1'b0;
  logic [4:0]       xrt = '0, rs = '0, drt = '0;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_fl, idex_fl, exmem_fl, memwb_fl, halt;
  logic [CNT_W-1:0] scnt;

  exp_t q[$];
  string names[$];
  int total = 0;
  int bad = 0;

  pipeline_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(1)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_ihit(ihit), .i_dhit(dhit), .i_dmem_req(dreq),
    .i_exmem_redirect(redir), .i_exmem_halt(hlt), .i_idex_memread(memrd),
    .i_idex_rt(xrt), .i_ifid_rs(rs), .i_ifid_rt(drt), .i_ifid_uses_rt(uses),
    .o_pc_en(pc_en), .o_ifid_en(ifid_en), .o_idex_en(idex_en), .o_exmem_en(exmem_en),
    .o_memwb_en(memwb_en), .o_ifid_flush(ifid_fl), .o_idex_flush(idex_fl),
    .o_exmem_flush(exmem_fl), .o_memwb_flush(memwb_fl), .o_halt(halt),
    .o_stall_count(scnt)
  );

  always #5 clk = ~clk;

  // Monitor: compare every queued expectation against the settled outputs
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e, a;
      string n;
      e = q.pop_front();
      n = names.pop_front();
      a = '{pc: pc_en, en: {ifid_en, idex_en, exmem_en, memwb_en},
            fl: {ifid_fl, idex_fl, exmem_fl, memwb_fl}, h: halt, c: scnt};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got pc=%b en=%b fl=%b halt=%b cnt=%0d, want pc=%b en=%b fl=%b halt=%b cnt=%0d",
                 n, a.pc, a.en, a.fl, a.h, a.c, e.pc, e.en, e.fl, e.h, e.c);
      end
    end
  end

  // Drive one cycle of inputs {rst_n,ihit,dhit,dreq,redir,halt} plus hazard fields
  task automatic step(input string n, input logic r, input logic ih, input logic dh,
                      input logic dq, input logic rd, input logic hl,
                      input logic mr, input logic [4:0] x, input logic [4:0] s,
                      input logic [4:0] t, input logic u,
                      input logic epc, input logic [3:0] een, input logic [3:0] efl,
                      input logic eh, input int ec);
    exp_t e;
    @(posedge clk);
    #1;
    nrst = r; ihit = ih; dhit = dh; dreq = dq; redir = rd; hlt = hl;
    memrd = mr; xrt = x; rs = s; drt = t; uses = u;
    e = '{pc: epc, en: een, fl: efl, h: eh, c: ec[3:0]};
    q.push_back(e);
    names.push_back(n);
  endtask

  task automatic norm(input string n, input int ec);
    step(n, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b1111, 4'b0000, 0, ec);
  endtask

  initial begin
    // reset: everything quiet
    step("reset", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    norm("run0", 0);
    norm("run1", 0);
    // memory wait three cycles, then completes
    for (int i = 0; i < 3; i++)
      step("memwait", 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, i);
    step("memdone", 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4'b1111, 4'b0000, 0, 3);
    norm("after_mem", 3);
    // load-use on rs
    step("lu_rs", 1, 1, 0, 0, 0, 0, 1, 8, 8, 0, 0, 0, 4'b0111, 4'b0100, 0, 3);
    norm("after_lu", 4);
    // r0 never creates a hazard
    step("lu_r0", 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 4'b1111, 4'b0000, 0, 4);
    // load-use on rt only when rt is read
    step("lu_rt", 1, 1, 0, 0, 0, 0, 1, 5, 3, 5, 1, 0, 4'b0111, 4'b0100, 0, 4);
    step("lu_rt_unused", 1, 1, 0, 0, 0, 0, 1, 5, 3, 5, 0, 1, 4'b1111, 4'b0000, 0, 5);
    // fetch miss
    step("imiss", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 4'b1000, 0, 5);
    norm("after_imiss", 6);
    // redirect beats load-use and fetch miss
    step("redirect", 1, 0, 0, 0, 1, 0, 1, 8, 8, 0, 0, 1, 4'b1111, 4'b1110, 0, 6);
    // mem wait masks redirect
    step("wait_redir", 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 6);
    norm("after_wr", 7);
    // halt outranks redirect; then one drain cycle that ignores inputs, then halted
    step("halt_entry", 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 4'b1111, 4'b1110, 0, 7);
    step("drain", 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 4'b1110, 0, 8);
    step("halted0", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 1, 8);
    step("halted1", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 1, 8);
    // reset pulse clears halt and count
    step("rst_pulse", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    norm("run_again", 0);
    // saturate the 4-bit counter
    for (int i = 0; i < 17; i++)
      step("sat", 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, (i > 15) ? 15 : i);
    // mem wait masks halt: no drain entry
    step("wait_halt", 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 15);
    norm("no_drain", 15);
    norm("no_drain2", 15);
    // let the monitor drain the queue, bounded
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_queue: %0d left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
